// File: rtl/delay_line_var.sv
// Variable-length delay line for a WIDTH-bit word plus valid flag, with stall,
// flush and a primed flag that tracks whether the selected depth has filled.
module delay_line_var #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 8,
    parameter int SELW      = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [SELW-1:0]  delay_sel,
    input  logic [WIDTH-1:0] datain,
    input  logic             valid_in,
    output logic [WIDTH-1:0] dataout,
    output logic             valid_out,
    output logic             primed
);

    localparam logic [SELW-1:0] MAXD = SELW'(MAX_DELAY);
    localparam logic [SELW-1:0] ONE  = SELW'(1);

    // Index 0 is the line input; index k is the output of stage k.
    logic [WIDTH-1:0] stage_data  [0:MAX_DELAY];
    logic             stage_valid [0:MAX_DELAY];

    logic [SELW-1:0] d;
    logic [SELW-1:0] d_reg;
    logic            d_seen_reg;
    logic            d_changed;
    logic [SELW-1:0] fill_cnt_reg;

    assign stage_data[0]  = datain;
    assign stage_valid[0] = valid_in;

    always_comb begin
        d = delay_sel;
        if (delay_sel == '0) begin
            d = ONE;
        end else if (delay_sel > MAXD) begin
            d = MAXD;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= MAX_DELAY; gi++) begin : gen_stage
            logic [WIDTH-1:0] data_reg;
            logic             valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (flush) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (en) begin
                    data_reg  <= stage_data[gi-1];
                    valid_reg <= stage_valid[gi-1];
                end
            end

            assign stage_data[gi]  = data_reg;
            assign stage_valid[gi] = valid_reg;
        end
    endgenerate

    // The first edge after reset has no previous d to compare against, so it
    // must not count as a change.
    assign d_changed = d_seen_reg && (d != d_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg        <= ONE;
            d_seen_reg   <= 1'b0;
            fill_cnt_reg <= '0;
        end else begin
            d_reg      <= d;
            d_seen_reg <= 1'b1;
            if (flush || d_changed) begin
                fill_cnt_reg <= '0;
            end else if (en && (fill_cnt_reg != MAXD)) begin
                fill_cnt_reg <= fill_cnt_reg + ONE;
            end
        end
    end

    assign dataout   = stage_data[d];
    assign valid_out = stage_valid[d];
    assign primed    = (fill_cnt_reg >= d);

endmodule

// File: tb/tb_delay_line_var.sv
// Directed bench for delay_line_var: a table-driven stream from reset plus
// hand-written stall, flush, delay-change and asynchronous-reset sequences.
module tb_delay_line_var;

    localparam int WIDTH     = 8;
    localparam int MAX_DELAY = 8;
    localparam int SELW      = $clog2(MAX_DELAY + 1);

    logic             clk;
    logic             rst;
    logic             en;
    logic             flush;
    logic [SELW-1:0]  delay_sel;
    logic [WIDTH-1:0] datain;
    logic             valid_in;
    logic [WIDTH-1:0] dataout;
    logic             valid_out;
    logic             primed;

    int n_checks;
    int n_fail;

    typedef struct {
        logic            en;
        logic            flush;
        logic [SELW-1:0] sel;
        logic [7:0]      din;
        logic            vin;
        logic [7:0]      dout;
        logic            vout;
        logic            prm;
    } vec_t;

    vec_t tbl [0:16];

    delay_line_var #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .delay_sel (delay_sel),
        .datain    (datain),
        .valid_in  (valid_in),
        .dataout   (dataout),
        .valid_out (valid_out),
        .primed    (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic f, input logic [SELW-1:0] s,
                                input logic [7:0] di, input logic vi,
                                input logic [7:0] dox, input logic vox, input logic px);
        vec_t v;
        v.en = e; v.flush = f; v.sel = s; v.din = di; v.vin = vi;
        v.dout = dox; v.vout = vox; v.prm = px;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] d, input logic v, input logic p);
        check({name, " dataout"}, 32'(dataout), 32'(d));
        check({name, " valid_out"}, 32'(valid_out), 32'(v));
        check({name, " primed"}, 32'(primed), 32'(p));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic f, input logic [7:0] di, input logic vi);
        en = e; flush = f; datain = di; valid_in = vi;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [7:0] stall_d [0:13];
        logic       stall_v [0:13];
        logic [7:0] nxt;

        n_checks = 0;
        n_fail   = 0;

        // d=3 pulse, then d=1 stream, then clamped d=8 stream
        tbl[0]  = mk(1, 0, 4'd3,  8'hA5, 1, 8'h00, 0, 0);
        tbl[1]  = mk(1, 0, 4'd3,  8'h00, 0, 8'h00, 0, 0);
        tbl[2]  = mk(1, 0, 4'd3,  8'h00, 0, 8'hA5, 1, 1);
        tbl[3]  = mk(1, 0, 4'd3,  8'h00, 0, 8'h00, 0, 1);
        tbl[4]  = mk(1, 0, 4'd3,  8'h00, 0, 8'h00, 0, 1);
        tbl[5]  = mk(1, 0, 4'd0,  8'h01, 1, 8'h01, 1, 0);
        tbl[6]  = mk(1, 0, 4'd0,  8'h02, 1, 8'h02, 1, 1);
        tbl[7]  = mk(1, 0, 4'd0,  8'h03, 1, 8'h03, 1, 1);
        tbl[8]  = mk(1, 0, 4'd15, 8'h04, 1, 8'h00, 0, 0);
        tbl[9]  = mk(1, 0, 4'd15, 8'h05, 1, 8'h00, 0, 0);
        tbl[10] = mk(1, 0, 4'd15, 8'h06, 1, 8'h00, 0, 0);
        tbl[11] = mk(1, 0, 4'd15, 8'h07, 1, 8'h00, 0, 0);
        tbl[12] = mk(1, 0, 4'd15, 8'h08, 1, 8'h01, 1, 0);
        tbl[13] = mk(1, 0, 4'd15, 8'h09, 1, 8'h02, 1, 0);
        tbl[14] = mk(1, 0, 4'd15, 8'h0A, 1, 8'h03, 1, 0);
        tbl[15] = mk(1, 0, 4'd15, 8'h0B, 1, 8'h04, 1, 0);
        tbl[16] = mk(1, 0, 4'd15, 8'h0C, 1, 8'h05, 1, 1);

        stall_d = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h11,
                    8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h00};
        stall_v = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

        rst = 1'b0;
        delay_sel = 4'd3;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        #1 rst = 1'b1;
        #1 check_out("reset", 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i <= 16; i++) begin
            delay_sel = tbl[i].sel;
            drive(tbl[i].en, tbl[i].flush, tbl[i].din, tbl[i].vin);
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].dout, tbl[i].vout, tbl[i].prm);
        end

        // Stall: d=4, two en-low cycles after the fourth sample enters
        delay_sel = 4'd4;
        do_reset();
        nxt = 8'h10;
        for (int i = 0; i < 14; i++) begin
            if (i == 4 || i == 5) begin
                drive(1'b0, 1'b0, 8'hEE, 1'b1);
            end else if (nxt <= 8'h17) begin
                drive(1'b1, 1'b0, nxt, 1'b1);
                nxt++;
            end else begin
                drive(1'b1, 1'b0, 8'h00, 1'b0);
            end
            tick();
            check($sformatf("stall e%0d dataout", i + 1), 32'(dataout), 32'(stall_d[i]));
            check($sformatf("stall e%0d valid_out", i + 1), 32'(valid_out), 32'(stall_v[i]));
            if (i == 2) check("stall e3 primed", 32'(primed), 32'd0);
            if (i >= 3) check($sformatf("stall e%0d primed", i + 1), 32'(primed), 32'd1);
        end

        // Flush: d=5, samples 20.. for 7 edges, flush with discarded input
        delay_sel = 4'd5;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 8'h20 + 8'(i), 1'b1);
            tick();
        end
        check_out("preflush", 8'h22, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 8'h99, 1'b1);
        tick();
        check_out("flush e0", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'h30 + 8'(i), 1'b1);
            tick();
            if (i < 4) check_out($sformatf("postflush e%0d", i + 1), 8'h00, 1'b0, 1'b0);
            else       check_out("postflush e5", 8'h30, 1'b1, 1'b1);
        end

        // Delay change 2 -> 6 mid-stream
        delay_sel = 4'd2;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'h40 + 8'(i), 1'b1);
            tick();
        end
        check_out("sel2", 8'h46, 1'b1, 1'b1);
        delay_sel = 4'd6;
        #1;
        check("sel6 tap dataout", 32'(dataout), 32'h42);
        check("sel6 tap valid_out", 32'(valid_out), 32'd1);
        for (int n = 9; n <= 15; n++) begin
            drive(1'b1, 1'b0, 8'h40 + 8'(n - 1), 1'b1);
            tick();
            check_out($sformatf("sel6 e%0d", n), 8'h40 + 8'(n - 6), 1'b1, (n == 15) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset between edges with a full valid pipeline
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_out("async rst", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/delay_line_var.md
Name: delay_line_var

Overview:
- Parametrised successor to the fixed-length single-bit delay.
- Delays a WIDTH-bit data word and its valid flag by a runtime-selectable number of clock cycles, from 1 to MAX_DELAY.
- Supports clock-enable stalling, a synchronous flush, and a "primed" status flag that marks when the selected pipeline depth has filled.
- Used for latency alignment between datapaths whose relative delay is configured at run time.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- MAX_DELAY, 8, number of physical delay stages (>=1)
- SELW, $clog2(MAX_DELAY+1), width of delay_sel (derived; do not override)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  shift enable; 0 = hold all state
- flush  input  1  synchronous clear of valid bits and data
- delay_sel  input  SELW  requested delay in cycles
- datain  input  WIDTH  input data word
- valid_in  input  1  qualifies datain
- dataout  output  WIDTH  delayed data word
- valid_out  output  1  delayed valid flag
- primed  output  1  high once the selected depth has filled since the last reset, flush or delay change

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On reset, all stage data is cleared to 0, all stage valid bits to 0, and fill_cnt to 0.
  - Resulting outputs: dataout=0, valid_out=0, primed=0.
- Storage: MAX_DELAY register stages s[1..MAX_DELAY], each holding {valid, data}.
- Effective delay d:
  - delay_sel = 0 gives d = 1.
  - delay_sel > MAX_DELAY gives d = MAX_DELAY.
  - Otherwise d = delay_sel.
- Shift, when en=1 and flush=0, at each rising edge:
  - s[1] <= {valid_in, datain}
  - s[k] <= s[k-1] for k = 2..MAX_DELAY
- en=0 with flush=0: all stages hold.
- Output tap:
  - dataout and valid_out = s[d], a mux of register outputs with no added register.
  - A sample presented at edge N with en high every cycle appears at the output after edge N+d-1, i.e. d cycles of latency.
- Stall: each en-low cycle adds exactly one cycle to the latency of every in-flight sample. No sample is lost or duplicated.
- Flush:
  - Takes priority over en.
  - Next edge: all stage valid bits and data go to 0, fill_cnt goes to 0.
  - datain and valid_in presented in the flush cycle are discarded.
- fill_cnt counter:
  - Counts edges with en=1 and flush=0 since the last reset, flush or change of d.
  - Saturates at MAX_DELAY.
  - primed = (fill_cnt >= d).
- Change of d between edges:
  - The output tap moves immediately, in the same cycle, to the new stage. No glitch beyond the normal mux change.
  - Stage contents are not altered.
  - fill_cnt is cleared to 0 at the next edge; the change is detected by a registered copy of d, and the clear takes priority over the increment.
  - primed therefore drops for at least the new d cycles.
- Valid propagation:
  - Bubbles (valid_in=0) travel through the line like data.
  - valid_out is never 1 for a slot that was cleared by reset or flush.
- Simultaneous flush and d change: flush behaviour applies; fill_cnt = 0.
- Reset mid-operation: all in-flight samples are lost immediately, outputs go to reset values, with no dependence on clk.

Test Plan:
- WIDTH=8, MAX_DELAY=8, delay_sel=3, en=1: drive datain=0xA5 with valid_in=1 for one cycle, then 0 -> dataout=0xA5 with valid_out=1 exactly 3 cycles later, for 1 cycle; primed rises after the 3rd edge following reset.
- delay_sel=0 and delay_sel=15 (clamp): stream 0x01,0x02,... -> latency 1 and 8 respectively; primed after 1 and 8 edges.
- delay_sel=4, stream 0x10..0x17, en low for 2 cycles mid-stream -> output sequence identical and contiguous in valid samples; total latency of the affected samples 6 cycles.
- Stream with delay_sel=5, assert flush for 1 cycle -> valid_out=0 and dataout=0 for the next 5 cycles; first post-flush sample emerges 5 cycles after entry; primed low for 5 edges.
- delay_sel changed 2->6 mid-stream -> tap switches the same cycle (older sample visible); primed low for 6 edges, then high.
- Assert rst asynchronously between edges with full valid pipeline -> dataout=0, valid_out=0, primed=0 before the next clk edge.
